// File: rtl/uart_fifo.sv
// uart_fifo: single-clock byte FIFO for the UART datapath.
// Registered read data. full and empty are decoded from wrap-bit pointers.
// Optional feature macro FIFO_ERR_FLAGS_EN adds sticky overflow and underflow outputs.
module uart_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              wclk,
  input  logic              rst_n,
  input  logic              wen,
  input  logic              ren,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_wptr;
  logic [ADDR_W:0]   r_rptr;
  logic [DATA_W-1:0] r_dout;
  logic              w_full;
  logic              w_empty;
  logic              w_wr_acc;
  logic              w_rd_acc;

  // Flags come only from the registered pointers. The top bit separates the
  // full case from the empty case when the index bits are equal.
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                    (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);
  assign w_wr_acc = wen && !w_full;
  assign w_rd_acc = ren && !w_empty;

  assign full     = w_full;
  assign empty    = w_empty;
  assign data_out = r_dout;

  // Storage write. The memory is not reset, so its contents after reset are don't-care.
  always_ff @(posedge wclk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr[ADDR_W-1:0]] <= data_in;
    end
  end

  // Write pointer advances on each accepted write and wraps modulo 2*DEPTH.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
    end else if (w_wr_acc) begin
      r_wptr <= r_wptr + PTR_ONE;
    end
  end

  // Read pointer and registered read data change only on an accepted read.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr <= '0;
      r_dout <= '0;
    end else if (w_rd_acc) begin
      r_rptr <= r_rptr + PTR_ONE;
      r_dout <= r_mem[r_rptr[ADDR_W-1:0]];
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic r_ovf;
  logic r_unf;

  // Sticky error flags record a write attempted while full or a read attempted while empty.
  // Only rst_n clears them.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= r_ovf | (wen & w_full);
      r_unf <= r_unf | (ren & w_empty);
    end
  end

  assign overflow  = r_ovf;
  assign underflow = r_unf;
`endif

endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo.
// The expected behaviour comes from a queue model of the FIFO.
module tb_uart_fifo;

  localparam int DW = 8;
  localparam int DP = 8;

  logic          wclk = 1'b0;
  logic          rst_n;
  logic          wen;
  logic          ren;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
`ifdef FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  uart_fifo #(.DATA_W(DW), .DEPTH(DP)) dut (
    .wclk     (wclk),
    .rst_n    (rst_n),
    .wen      (wen),
    .ren      (ren),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  always #5 wclk = ~wclk;

  // Reference model state.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_ovf;
  logic          m_unf;
  bit            chk_en;
  int            total;
  int            bad;

  logic [DW-1:0] fill_tab [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // Apply one cycle of requests.
  // The model then advances using its pre-edge occupancy.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    int sz;
    wen     = w;
    ren     = r;
    data_in = d;
    @(posedge wclk);
    sz = q.size();
    if (w && sz == DP) m_ovf = 1'b1;
    if (r && sz == 0)  m_unf = 1'b1;
    if (r && sz > 0)   m_dout = q.pop_front();
    if (w && sz < DP)  q.push_back(d);
    #1;
    wen = 1'b0;
    ren = 1'b0;
  endtask

  // Compare the DUT against the model once per cycle, away from the active edge.
  always @(negedge wclk) begin
    if (chk_en) begin
      chk("cyc_empty", {31'd0, empty}, {31'd0, q.size() == 0});
      chk("cyc_full",  {31'd0, full},  {31'd0, q.size() == DP});
      chk("cyc_dout",  {24'd0, data_out}, {24'd0, m_dout});
`ifdef FIFO_ERR_FLAGS_EN
      chk("cyc_ovf", {31'd0, overflow},  {31'd0, m_ovf});
      chk("cyc_unf", {31'd0, underflow}, {31'd0, m_unf});
`endif
    end
  end

  initial begin
    int wp;
    int rp;
    total  = 0;
    bad    = 0;
    chk_en = 1'b0;
    fill_tab = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12};
    rst_n   = 1'b0;
    wen     = 1'b0;
    ren     = 1'b0;
    data_in = '0;
    model_reset();

    // Reset state
    #25;
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full",  {31'd0, full},  32'd0);
    chk("rst_dout",  {24'd0, data_out}, 32'h00);
`ifdef FIFO_ERR_FLAGS_EN
    chk("rst_ovf", {31'd0, overflow},  32'd0);
    chk("rst_unf", {31'd0, underflow}, 32'd0);
`endif
    #27;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(posedge wclk);
    #1;

    // Fill
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, fill_tab[i]);
      chk("fill_empty", {31'd0, empty}, 32'd0);
      chk("fill_full",  {31'd0, full},  (i == 7) ? 32'd1 : 32'd0);
    end

    // Drain
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("drain_dout",  {24'd0, data_out}, {24'd0, fill_tab[i]});
      chk("drain_full",  {31'd0, full}, 32'd0);
      chk("drain_empty", {31'd0, empty}, (i == 7) ? 32'd1 : 32'd0);
    end

    // Overflow: refill, then write AA while full
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, fill_tab[i]);
    step(1'b1, 1'b0, 8'hAA);
    chk("ovf_full", {31'd0, full}, 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
`endif
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("ovf_dout", {24'd0, data_out}, {24'd0, fill_tab[i]});
    end
    chk("ovf_empty", {31'd0, empty}, 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
`endif

    // Underflow and hold
    step(1'b0, 1'b1, 8'h00);
    chk("unf_dout",  {24'd0, data_out}, 32'h12);
    chk("unf_empty", {31'd0, empty}, 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("unf_flag", {31'd0, underflow}, 32'd1);
`endif

    // Simultaneous write and read while empty: the write wins, and data_out holds
    step(1'b1, 1'b1, 8'hF0);
    chk("we_empty_dout",  {24'd0, data_out}, 32'h12);
    chk("we_empty_empty", {31'd0, empty}, 32'd0);
    for (int i = 1; i < 4; i++) step(1'b1, 1'b0, 8'hF0 + 8'(i));

    // Concurrent and wrap: 4 entries stored, 20 cycles of write and read together
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1, 8'(k));
      chk("conc_occ",   q.size(), 32'd4);
      chk("conc_full",  {31'd0, full},  32'd0);
      chk("conc_empty", {31'd0, empty}, 32'd0);
      chk("conc_dout",  {24'd0, data_out}, (k < 4) ? (32'hF0 + 32'(k)) : 32'(k - 4));
    end

    // Simultaneous write and read while full: the read wins, and full deasserts
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'hC0 + 8'(i));
    chk("wf_full_pre", {31'd0, full}, 32'd1);
    step(1'b1, 1'b1, 8'hEE);
    chk("wf_dout", {24'd0, data_out}, 32'h10);
    chk("wf_full", {31'd0, full}, 32'd0);

    // Randomized traffic with varying write/read bias and one asynchronous mid-run reset
    for (int c = 0; c < 800; c++) begin
      case ((c / 50) % 3)
        0:       begin wp = 80; rp = 30; end
        1:       begin wp = 30; rp = 80; end
        default: begin wp = 60; rp = 60; end
      endcase
      step(($urandom_range(0, 99) < wp) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < rp) ? 1'b1 : 1'b0,
           8'($urandom_range(0, 255)));
      if (c == 400) begin
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_dout",  {24'd0, data_out}, 32'h00);
        chk("arst_empty", {31'd0, empty}, 32'd1);
        chk("arst_full",  {31'd0, full},  32'd0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("arst_ovf", {31'd0, overflow},  32'd0);
        chk("arst_unf", {31'd0, underflow}, 32'd0);
`endif
        #1;
        rst_n = 1'b1;
      end
    end

    @(negedge wclk);
    #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
